fifo_serializer: RTL and testbench
==================================

FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits, equal to the upstream FIFO width.
REQ-002 Parameter CLKS_PER_BIT, default 4: clk cycles per serial bit, legal range 2..255.
REQ-003 Port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port tx_en  input  1  enables fetching of new words from the FIFO.
REQ-006 Port fifo_empty  input  1  FIFO empty flag.
REQ-007 Port fifo_data_out  input  WIDTH  FIFO read data, valid the cycle after a fifo_read pulse.
REQ-008 Port fifo_read  output  1  one-cycle pop request to the FIFO.
REQ-009 Port tx_serial  output  1  serial line; idles high.
REQ-010 Port tx_busy  output  1  high from FETCH through the last STOP cycle.
REQ-011 Port frame_done  output  1  one-cycle pulse in the final clk of each STOP bit.

Function
REQ-012 The FSM SHALL have states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-013 IDLE -> FETCH when tx_en=1 and fifo_empty=0; otherwise remain in IDLE.
REQ-014 FETCH SHALL last exactly 1 cycle with fifo_read=1, then go to LOAD.
REQ-015 LOAD SHALL capture fifo_data_out into the shift register in 1 cycle, then go to START.
REQ-016 fifo_read SHALL be asserted only in FETCH, never while fifo_empty=1, and exactly once per frame.
REQ-017 START SHALL drive tx_serial=0 for CLKS_PER_BIT cycles.
REQ-018 DATA SHALL shift WIDTH bits MSB first, each bit held for CLKS_PER_BIT cycles, counted by a bit counter wide enough for WIDTH-1.
REQ-019 PARITY, present only per REQ-030, SHALL drive the even-parity bit (XOR of all WIDTH data bits) for CLKS_PER_BIT cycles.
REQ-020 STOP SHALL drive tx_serial=1 for CLKS_PER_BIT cycles and pulse frame_done in its last cycle.
REQ-021 On leaving STOP, the FSM SHALL go directly to FETCH if tx_en=1 and fifo_empty=0, else to IDLE, so back-to-back frames have no idle gap.
REQ-022 Frame length SHALL be (WIDTH+2)*CLKS_PER_BIT line cycles, or (WIDTH+3)*CLKS_PER_BIT with parity.
REQ-023 Latency from IDLE with a word available to the falling edge of the start bit SHALL be 3 cycles (FETCH, LOAD, first START cycle).
REQ-024 Deasserting tx_en mid-frame SHALL NOT abort the frame; it only blocks the next fetch.
REQ-025 A change on fifo_empty outside IDLE and STOP exit SHALL have no effect.
REQ-026 tx_serial SHALL be driven from a register (glitch-free); tx_busy=0 only in IDLE.

Reset
REQ-027 While rst=1: state=IDLE, tx_serial=1, fifo_read=0, tx_busy=0, frame_done=0, and all counters and the shift register=0.
REQ-028 Reset asserted mid-frame SHALL abort immediately and asynchronously, returning the line high; the partially sent word is lost and not re-fetched.
REQ-029 After rst deasserts, the first FETCH SHALL occur no earlier than the first rising edge with rst=0.

Configuration
REQ-030 Macro SERIALIZER_PARITY_EN: when defined, the PARITY state is inserted between DATA and STOP; when undefined, the PARITY state and its logic are absent and DATA goes straight to STOP.

Verification
REQ-031 Single word: FIFO holds 16'h18E9, tx_en=1, CLKS_PER_BIT=4 -> one fifo_read pulse; line shows 0, then 0001100011101001 MSB first, then 1; frame_done at cycle 72 after START begins (parity undefined).
REQ-032 Parity on: same word with SERIALIZER_PARITY_EN -> parity bit=1 (7 ones) before STOP; frame spans 76 cycles.
REQ-033 Back-to-back: FIFO holds 16'h18E9 and 16'hA9BA -> second fifo_read in the cycle after the first frame_done; exactly 2 reads; FSM ends in IDLE with tx_busy=0.
REQ-034 Empty FIFO: fifo_empty=1, tx_en=1 for 50 cycles -> fifo_read stays 0, tx_serial stays 1, tx_busy stays 0.
REQ-035 tx_en dropped during DATA bit 5 with FIFO non-empty -> current frame completes intact; no further fifo_read.
REQ-036 rst pulsed during DATA bit 8 -> tx_serial=1 and tx_busy=0 immediately; the next frame after release starts with a fresh fetch.

Source files
------------

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from a FIFO and sends them as start/MSB-first data/stop frames.
// Define SERIALIZER_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_serializer #(
   parameter int WIDTH        = 16,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data_out,
   output logic             fifo_read,
   output logic             tx_serial,
   output logic             tx_busy,
   output logic             frame_done
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] START  = 3'd3;
   localparam logic [2:0] DATA   = 3'd4;
   localparam logic [2:0] STOP   = 3'd5;
`ifdef SERIALIZER_PARITY_EN
   localparam logic [2:0] PARITY = 3'd6;
`endif
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [7:0]    LAST     = 8'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   logic [2:0]       state;
   logic [7:0]       cnt;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shreg;
   logic             bit_end;
   logic             start_ok;
`ifdef SERIALIZER_PARITY_EN
   logic             par;
`endif

   assign bit_end    = cnt == LAST;
   assign start_ok   = tx_en && !fifo_empty;
   assign fifo_read  = state == FETCH;
   assign tx_busy    = state != IDLE;
   assign frame_done = state == STOP && bit_end;

   // tx_serial is loaded on the edge that enters each bit, so the line is a pure register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         tx_serial <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE:  if (start_ok) state <= FETCH;
            FETCH: state <= LOAD;
            LOAD: begin
               shreg     <= fifo_data_out;
`ifdef SERIALIZER_PARITY_EN
               par       <= ^fifo_data_out;
`endif
               cnt       <= '0;
               tx_serial <= 1'b0;
               state     <= START;
            end
            START: begin
               if (bit_end) begin
                  cnt       <= '0;
                  bit_cnt   <= '0;
                  tx_serial <= shreg[WIDTH-1];
                  state     <= DATA;
               end else cnt <= cnt + 8'd1;
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_cnt == LAST_BIT) begin
`ifdef SERIALIZER_PARITY_EN
                     tx_serial <= par;
                     state     <= PARITY;
`else
                     tx_serial <= 1'b1;
                     state     <= STOP;
`endif
                  end else begin
                     bit_cnt   <= bit_cnt + BW'(1);
                     shreg     <= shreg << 1;
                     tx_serial <= shreg[WIDTH-2];
                  end
               end else cnt <= cnt + 8'd1;
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  cnt       <= '0;
                  tx_serial <= 1'b1;
                  state     <= STOP;
               end else cnt <= cnt + 8'd1;
            end
`endif
            STOP: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= start_ok ? FETCH : IDLE;
               end else cnt <= cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed and random frames against a timeline model of the serial line.
module tb_fifo_serializer;
   localparam int W   = 16;
   localparam int CPB = 4;
`ifdef SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME = 2 + (W + 2 + PAR) * CPB;

   logic clk = 0, rst = 1, tx_en = 0, fifo_empty = 1;
   logic [W-1:0] fifo_data_out = '0;
   logic fifo_read, tx_serial, tx_busy, frame_done;

   fifo_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out), .fifo_read(fifo_read), .tx_serial(tx_serial),
      .tx_busy(tx_busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0, reads = 0, dones = 0, m_t = 0, done_cyc = 0, read_cyc = 0;
   logic m_active = 0, rd_seen = 0, push_en = 0, flush = 0;
   logic [W-1:0] m_word = '0, push_val = '0;
   logic [W-1:0] q[$], mq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Expected line level from the frame position: t=0 fetch, t=1 load, then bit slots of CPB cycles
   function automatic logic exp_line();
      int k;
      if (!m_active || rst || m_t < 2) return 1'b1;
      k = (m_t - 2) / CPB;
      if (k == 0) return 1'b0;
      if (k <= W) return m_word[W-k];
      if (PAR == 1 && k == W + 1) return ^m_word;
      return 1'b1;
   endfunction

   // Model step and FIFO behaviour share one clocked process so their order is fixed
   always @(posedge clk) begin
      cyc++;
      if (rst) m_active = 0;
      else if (m_active && m_t + 1 < FRAME) m_t++;
      else if (tx_en && !fifo_empty && mq.size() > 0) begin
         m_active = 1;
         m_t = 0;
         m_word = mq.pop_front();
      end else m_active = 0;
      if (!rst && rd_seen && q.size() > 0) fifo_data_out <= q.pop_front();
      if (push_en) begin
         q.push_back(push_val);
         mq.push_back(push_val);
      end
      if (flush) begin
         q.delete();
         mq.delete();
      end
      fifo_empty <= q.size() == 0;
   end

   always @(negedge clk) begin
      logic act;
      act = m_active && !rst;
      rd_seen = fifo_read;
      if (fifo_read) begin reads++; read_cyc = cyc; end
      if (frame_done) begin dones++; done_cyc = cyc; end
      chk("fifo_read", 32'(fifo_read), 32'(act && m_t == 0));
      chk("tx_busy", 32'(tx_busy), 32'(act));
      chk("frame_done", 32'(frame_done), 32'(act && m_t == FRAME - 1));
      chk("tx_serial", 32'(tx_serial), 32'(exp_line()));
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic push(input logic [W-1:0] w);
      push_en = 1; push_val = w; tick(); push_en = 0;
   endtask

   task automatic do_flush();
      flush = 1; tick(); flush = 0; tick();
   endtask

   task automatic wait_dones(input int n, input int lim);
      int k = 0;
      while (dones < n && k < lim) begin tick(); k++; end
      chk("done_timeout", 32'(dones >= n), 1);
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (tx_busy && k < lim) begin tick(); k++; end
      chk("idle_timeout", 32'(tx_busy), 0);
   endtask

   task automatic wait_fall(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (tx_serial && n < 50);
   endtask

   initial begin
      int r0, d0, n, s, dc1;
      logic [W-1:0] w;
      tick(3);
      @(negedge clk);
      chk("reset_serial", 32'(tx_serial), 1);
      chk("reset_busy", 32'(tx_busy), 0);
      chk("reset_read", 32'(fifo_read), 0);
      tick();
      rst = 0;
      // empty FIFO with tx_en high
      tx_en = 1; r0 = reads;
      tick(50);
      chk("empty_reads", 32'(reads - r0), 0);
      chk("empty_serial", 32'(tx_serial), 1);
      // single word, literal waveform
      tx_en = 0;
      push(16'h18E9);
      tick();
      r0 = reads; d0 = dones;
      tx_en = 1;
      wait_fall(n);
      chk("start_latency", 32'(n), 4);
      s = cyc;
      w = '0;
      for (int i = 0; i < W; i++) begin
         repeat (CPB) @(negedge clk);
         w = {w[W-2:0], tx_serial};
      end
      chk("data_word", 32'(w), 32'h18E9);
`ifdef SERIALIZER_PARITY_EN
      repeat (CPB) @(negedge clk);
      chk("parity_bit", 32'(tx_serial), 1);
`endif
      wait_dones(d0 + 1, 200);
      chk("frame_len", 32'(done_cyc - s + 1), PAR ? 76 : 72);
      chk("single_reads", 32'(reads - r0), 1);
      wait_idle(20);
      // back-to-back frames
      tx_en = 0;
      push(16'h18E9);
      push(16'hA9BA);
      r0 = reads; d0 = dones;
      tx_en = 1;
      wait_dones(d0 + 1, 300);
      dc1 = done_cyc;
      wait_dones(d0 + 2, 300);
      chk("b2b_gap", 32'(read_cyc - dc1), 1);
      chk("b2b_reads", 32'(reads - r0), 2);
      wait_idle(20);
      // tx_en dropped during data bit 5
      tx_en = 0;
      do_flush();
      for (int i = 0; i < 3; i++) push(W'($urandom));
      r0 = reads;
      tx_en = 1;
      wait_fall(n);
      repeat (CPB * 6 + 1) @(negedge clk);
      tx_en = 0;
      wait_idle(200);
      chk("drop_reads", 32'(reads - r0), 1);
      do_flush();
      // reset during data bit 8
      push(W'($urandom));
      push(W'($urandom));
      r0 = reads;
      tx_en = 1;
      wait_fall(n);
      repeat (CPB * 9 + 1) @(negedge clk);
      #2 rst = 1;
      #1;
      chk("rst_serial", 32'(tx_serial), 1);
      chk("rst_busy", 32'(tx_busy), 0);
      tick(2);
      rst = 0;
      d0 = dones;
      wait_dones(d0 + 1, 200);
      chk("rst_reads", 32'(reads - r0), 2);
      tx_en = 0;
      wait_idle(20);
      // random traffic
      do_flush();
      tx_en = 1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(0, 19) == 0) tx_en = ~tx_en;
         if (q.size() < 4 && $urandom_range(0, 7) == 0) push(W'($urandom));
      end
      tx_en = 0;
      wait_idle(200);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
